// File: rtl/audio_feeder_pkg.sv
// audio_feeder_pkg
//   Shared definitions for the audio sample feeder: register word
//   addresses, CTRL/STATUS bit positions, output FSM state encoding and
//   the stereo sample word as it arrives on the Avalon-MM DATA register.
package audio_feeder_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_VOL    = 3'd3;
  localparam logic [2:0] ADDR_THRESH = 3'd4;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_MUTE   = 1;
  localparam int CTRL_CLEAR  = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions; level occupies [LEVEL_FIELD_W-1:0]
  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_UNDERRUN = 18;
  localparam int STAT_OVERFLOW = 19;

  localparam int LEVEL_FIELD_W = 16;
  localparam int THRESH_W      = 16;
  localparam int VOL_W         = 4;
  localparam int BUS_SAMPLE_W  = 16;  // per-channel width on the bus

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2
  } feed_state_e;

  // One stereo entry as written to DATA: left in the upper half.
  typedef struct packed {
    logic [BUS_SAMPLE_W-1:0] left;
    logic [BUS_SAMPLE_W-1:0] right;
  } stereo_sample_t;

  function automatic stereo_sample_t unpack_word(input logic [31:0] w);
    return stereo_sample_t'(w);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//   Single-clock FIFO on an inferred RAM with a registered head word.
//   The head register always holds the entry at the read pointer, so a
//   consumer may take `head` in any cycle where `empty` is low.
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   push/push_data : write request (dropped when full or clearing)
//   pop         : advance the head (ignored when empty or clearing)
//   clear       : empty the FIFO at the next edge
//   head        : current oldest entry
//   full, empty, level : occupancy
module sample_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers wrap naturally since DEPTH is a power of two.
  assign rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head register reads ahead at the next read pointer. When the entry
  // being written lands exactly there (empty FIFO, or last entry popped
  // in the same cycle) the RAM has not got it yet, so bypass the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
    end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head <= push_data;
    end else begin
      head <= mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder
//   Avalon-MM register slave that buffers stereo samples from the HPS
//   and streams them to the audio codec core over two Avalon-ST channels.
//   Each LOAD pops one FIFO entry (or zeros on underrun), applies volume
//   attenuation and mute, and PRESENT holds both channels until each has
//   handshaken independently.
// Build option
//   AUDIO_FEEDER_IRQ_EN : enables the low-water/underrun interrupt, the
//                         CTRL irq-enable bit and the THRESH register.
// Ports
//   clk, reset                        : 50 MHz clock, sync active-high reset
//   chipselect, write, read, address,
//   writedata, readdata               : Avalon-MM slave, zero read latency
//   left_data/valid/ready,
//   right_data/valid/ready            : Avalon-ST sample outputs
//   irq                               : level interrupt
module audio_sample_feeder
  import audio_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [SAMPLE_W-1:0] left_data,
  output logic                left_valid,
  input  logic                left_ready,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                right_valid,
  input  logic                right_ready,
  output logic                irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NUM_CH = 2;  // index 1 = left, 0 = right

  // ---------------- register interface ----------------
  logic reg_wr, reg_rd, data_wr, status_rd;
  assign reg_wr    = chipselect && write;
  assign reg_rd    = chipselect && read;
  assign data_wr   = reg_wr && (address == ADDR_DATA);
  assign status_rd = reg_rd && (address == ADDR_STATUS);

  logic               enable_q, mute_q, clear_q;
  logic [VOL_W-1:0]   vol_q;
  logic               underrun_q, overflow_q;
  logic               irq_en_q;
  logic [THRESH_W-1:0] thresh_q;

  // FIFO
  stereo_sample_t     fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [LVL_W-1:0]   fifo_level;

  // FSM
  feed_state_e state_q, state_d;
  logic        load_fire, present_done;

  logic underrun_evt, overflow_evt;
  assign underrun_evt = load_fire && fifo_empty;
  // A push during clear is discarded by the FIFO, not counted as overflow.
  assign overflow_evt = data_wr && fifo_full && !clear_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= 1'b0;
      mute_q     <= 1'b0;
      clear_q    <= 1'b0;
      vol_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // clear is a one-cycle pulse; it is registered so a DATA write in
      // the following cycle coincides with it and is discarded.
      clear_q <= 1'b0;
      if (reg_wr && (address == ADDR_CTRL)) begin
        enable_q <= writedata[CTRL_ENABLE];
        mute_q   <= writedata[CTRL_MUTE];
        clear_q  <= writedata[CTRL_CLEAR];
      end
      if (reg_wr && (address == ADDR_VOL)) vol_q <= writedata[VOL_W-1:0];
      // New events win over a read-clear in the same cycle.
      if (status_rd) begin
        underrun_q <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (underrun_evt) underrun_q <= 1'b1;
      if (overflow_evt) overflow_q <= 1'b1;
    end
  end

`ifdef AUDIO_FEEDER_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      thresh_q <= '0;
    end else begin
      if (reg_wr && (address == ADDR_CTRL))   irq_en_q <= writedata[CTRL_IRQ_EN];
      if (reg_wr && (address == ADDR_THRESH)) thresh_q <= writedata[THRESH_W-1:0];
    end
  end

  logic [LEVEL_FIELD_W-1:0] level_ext;
  assign level_ext = LEVEL_FIELD_W'(fifo_level);
  assign irq = irq_en_q && ((level_ext < thresh_q) || underrun_q);
`else
  assign irq_en_q = 1'b0;
  assign thresh_q = '0;
  assign irq      = 1'b0;
`endif

  // Zero-latency read mux.
  always_comb begin
    readdata = '0;
    if (!reset && reg_rd) begin
      unique case (address)
        ADDR_CTRL: begin
          readdata[CTRL_ENABLE] = enable_q;
          readdata[CTRL_MUTE]   = mute_q;
          readdata[CTRL_CLEAR]  = clear_q;
          readdata[CTRL_IRQ_EN] = irq_en_q;
        end
        ADDR_STATUS: begin
          readdata[LVL_W-1:0]    = fifo_level;
          readdata[STAT_EMPTY]    = fifo_empty;
          readdata[STAT_FULL]     = fifo_full;
          readdata[STAT_UNDERRUN] = underrun_q;
          readdata[STAT_OVERFLOW] = overflow_q;
        end
        ADDR_VOL:    readdata[VOL_W-1:0]    = vol_q;
        ADDR_THRESH: readdata[THRESH_W-1:0] = thresh_q;
        default:     readdata = '0;  // DATA is write-only; 5..7 unmapped
      endcase
    end
  end

  // ---------------- FIFO ----------------
  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(stereo_sample_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (unpack_word(writedata)),
    .pop       (fifo_pop),
    .clear     (clear_q),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // ---------------- output FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Disabling outside PRESENT returns to IDLE without consuming.
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else begin
          load_fire = 1'b1;
          fifo_pop  = !fifo_empty;
          state_d   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (present_done) state_d = enable_q ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- per-channel datapath ----------------
  logic [NUM_CH-1:0][BUS_SAMPLE_W-1:0] head_ch;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     data_q;
  logic [NUM_CH-1:0]                   vld_q, ch_ready;

  assign head_ch  = {fifo_head.left, fifo_head.right};
  assign ch_ready = {left_ready, right_ready};

  // A channel is finished once its valid is already low or is being
  // accepted this cycle.
  assign present_done = &(~vld_q | ch_ready);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic signed [SAMPLE_W-1:0] ext;
    logic signed [SAMPLE_W-1:0] scaled;

    if (SAMPLE_W > BUS_SAMPLE_W) begin : g_wide
      assign ext = {{(SAMPLE_W-BUS_SAMPLE_W){head_ch[ch][BUS_SAMPLE_W-1]}}, head_ch[ch]};
    end else begin : g_narrow
      assign ext = head_ch[ch][BUS_SAMPLE_W-1 -: SAMPLE_W];
    end

    assign scaled = ext >>> vol_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q[ch] <= '0;
        vld_q[ch]  <= 1'b0;
      end else if (load_fire) begin
        data_q[ch] <= (fifo_empty || mute_q) ? '0 : scaled;
        vld_q[ch]  <= 1'b1;
      end else if (vld_q[ch] && ch_ready[ch]) begin
        vld_q[ch]  <= 1'b0;
      end
    end
  end

  assign left_data   = data_q[1];
  assign right_data  = data_q[0];
  assign left_valid  = vld_q[1];
  assign right_valid = vld_q[0];

endmodule

// File: tb/tb_audio_sample_feeder.sv
module tb_audio_sample_feeder;

  localparam int DEPTH = 16;
  localparam int SW    = 16;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_VOL    = 3'd3;
  localparam logic [2:0] A_THRESH = 3'd4;

`ifdef AUDIO_FEEDER_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect, write, read;
  logic [2:0]    address;
  logic [31:0]   writedata, readdata;
  logic [SW-1:0] left_data, right_data;
  logic          left_valid, right_valid, left_ready, right_ready;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  audio_sample_feeder #(.FIFO_DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .left_data   (left_data),
    .left_valid  (left_valid),
    .left_ready  (left_ready),
    .right_data  (right_data),
    .right_valid (right_valid),
    .right_ready (right_ready),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the next posedge and
  // the task returns at the negedge after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          exp_idx;

    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; left_ready = 1'b1; right_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lvalid", 32'(left_valid), 0);
    check("rst_rvalid", 32'(right_valid), 0);
    check("rst_data", {left_data, right_data}, 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_readdata", readdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // ---- register map ----
    rd(A_STATUS, d); check("status_after_reset", d, 32'h0001_0000);
    rd(A_CTRL, d);   check("ctrl_after_reset", d, 0);
    wr(A_VOL, 32'hFFFF_FFF5);
    rd(A_VOL, d);    check("vol_readback", d, 32'h5);
    wr(A_THRESH, 32'h1234_0007);
    rd(A_THRESH, d); check("thresh_readback", d, IRQ_BUILD ? 32'h7 : 32'h0);
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, d);   check("ctrl_irq_en_bit", d, IRQ_BUILD ? 32'h8 : 32'h0);
    wr(A_CTRL, 32'h0);
    wr(A_VOL, 32'h0);
    for (int a = 5; a < 8; a++) begin
      wr(3'(a), 32'hDEAD_BEEF);
      rd(3'(a), d); check("unmapped_read", d, 0);
    end

    // ---- single sample latency: write at E0, enable at E1, valid after E3 ----
    wr(A_DATA, 32'h1234_FF00);
    wr(A_CTRL, 32'h1);
    check("lat_no_valid_e1", 32'(left_valid), 0);
    @(negedge clk);
    check("lat_no_valid_e2", 32'(left_valid), 0);
    @(negedge clk);
    check("lat_valid_e3", {30'd0, left_valid, right_valid}, 32'h3);
    check("lat_data", {left_data, right_data}, 32'h1234_FF00);
    rd(A_STATUS, d); check("lat_level_zero", d, 32'h0001_0000);
    check("lat_valid_dropped", 32'(left_valid), 0);

    // ---- underrun: FSM keeps loading from an empty FIFO ----
    @(negedge clk);
    check("underrun_valid", {30'd0, left_valid, right_valid}, 32'h3);
    check("underrun_zero", {left_data, right_data}, 0);
    wr(A_CTRL, 32'h0);
    rd(A_STATUS, d); check("underrun_sticky", d, 32'h0005_0000);
    rd(A_STATUS, d); check("underrun_cleared", d, 32'h0001_0000);

    // ---- volume and mute ----
    wr(A_VOL, 32'h4);
    wr(A_DATA, 32'h8000_7FF0);
    wr(A_CTRL, 32'h1);
    @(negedge clk); @(negedge clk);
    check("vol_valid", 32'(left_valid), 1);
    check("vol_shift", {left_data, right_data}, 32'hF800_07FF);
    wr(A_CTRL, 32'h0);
    wr(A_DATA, 32'h8000_8000);
    wr(A_CTRL, 32'h3);
    @(negedge clk); @(negedge clk);
    check("mute_valid", 32'(right_valid), 1);
    check("mute_zero", {left_data, right_data}, 0);
    wr(A_CTRL, 32'h0);
    wr(A_VOL, 32'h0);
    rd(A_STATUS, d);  // drop any sticky state before the next step

    // ---- right channel back-pressure ----
    wr(A_DATA, 32'h1111_2222);
    wr(A_DATA, 32'h3333_4444);
    right_ready = 1'b0;
    wr(A_CTRL, 32'h1);
    @(negedge clk); @(negedge clk);
    check("bp_both_valid", {30'd0, left_valid, right_valid}, 32'h3);
    check("bp_first_data", {left_data, right_data}, 32'h1111_2222);
    @(negedge clk);
    check("bp_left_done", {30'd0, left_valid, right_valid}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd(A_STATUS, d);
      check("bp_right_held", {15'd0, right_valid, right_data}, 32'h0001_2222);
      check("bp_no_pop", 32'(d[15:0]), 32'h1);
    end
    right_ready = 1'b1;
    @(negedge clk);
    check("bp_right_done", 32'(right_valid), 0);
    @(negedge clk);
    check("bp_second_valid", {30'd0, left_valid, right_valid}, 32'h3);
    check("bp_second_data", {left_data, right_data}, 32'h3333_4444);
    wr(A_CTRL, 32'h0);
    rd(A_STATUS, d);

    // ---- overflow: DEPTH+1 writes while disabled ----
    for (int i = 0; i <= DEPTH; i++) wr(A_DATA, 32'(i));
    rd(A_STATUS, d); check("ovf_status", d, 32'h000A_0000 | 32'(DEPTH));
    rd(A_STATUS, d); check("ovf_cleared", d, 32'h0002_0000 | 32'(DEPTH));
    exp_idx = 0;
    wr(A_CTRL, 32'h1);
    for (int k = 0; k < 20 * DEPTH && exp_idx < DEPTH; k++) begin
      if (right_valid) begin
        check("drain_sample", {left_data, right_data}, 32'(exp_idx));
        exp_idx++;
      end
      if (exp_idx < DEPTH) @(negedge clk);
    end
    check("drain_count", 32'(exp_idx), 32'(DEPTH));
    @(negedge clk); @(negedge clk);
    check("drain_dropped_valid", 32'(right_valid), 1);
    check("drain_dropped_absent", {left_data, right_data}, 0);
    wr(A_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    rd(A_STATUS, d);
    rd(A_STATUS, d); check("drain_status_empty", d, 32'h0001_0000);

    // ---- clear, with a DATA write in the following cycle ----
    wr(A_DATA, 32'hAAAA_0001);
    wr(A_DATA, 32'hAAAA_0002);
    wr(A_DATA, 32'hAAAA_0003);
    wr(A_CTRL, 32'h4);
    wr(A_DATA, 32'hBBBB_0004);
    rd(A_STATUS, d); check("clear_empty", d, 32'h0001_0000);
    rd(A_CTRL, d);   check("clear_self_clear", d, 0);

    // ---- low-water interrupt, then reset mid-PRESENT ----
    for (int i = 1; i <= 5; i++) wr(A_DATA, 32'(i));
    wr(A_THRESH, 32'h4);
    wr(A_CTRL, 32'h9);
    check("irq_level5", 32'(irq), 0);
    @(negedge clk); @(negedge clk);
    check("irq_level4", 32'(irq), 0);
    check("irq_present1", {left_data, right_data}, 32'h1);
    @(negedge clk); @(negedge clk);
    check("irq_level3", 32'(irq), 32'(IRQ_BUILD));
    check("mid_present_valid", {30'd0, left_valid, right_valid}, 32'h3);
    check("mid_present_data", {left_data, right_data}, 32'h2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {30'd0, left_valid, right_valid}, 0);
    check("rst_mid_data", {left_data, right_data}, 0);
    check("rst_mid_irq", 32'(irq), 0);
    check("rst_mid_readdata", readdata, 0);
    reset = 1'b0;
    @(negedge clk);
    rd(A_STATUS, d); check("post_reset_status", d, 32'h0001_0000);
    rd(A_CTRL, d);   check("post_reset_ctrl", d, 0);
    rd(A_THRESH, d); check("post_reset_thresh", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 256, number of stereo sample entries; power of two, 16..1024.
REQ-002 Parameter SAMPLE_W, default 16, width in bits of each channel's signed sample.
REQ-003 clk  in  1  single system clock (50 MHz); all logic is synchronous to it.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 chipselect, write, read  in  1 each  Avalon-MM slave strobes from the HPS lightweight bridge.
REQ-006 address  in  3  register word address.
REQ-007 writedata  in  32  write data; readdata  out  32  read data, zero read latency.
REQ-008 left_data, right_data  out  SAMPLE_W  Avalon-ST samples to the audio_0 codec core.
REQ-009 left_valid, right_valid  out  1 each; left_ready, right_ready  in  1 each  Avalon-ST handshake per channel.
REQ-010 irq  out  1  level interrupt to the HPS.

Function
REQ-011 Register map (word addresses):
- 0 DATA: write pushes {L=writedata[31:16], R=writedata[15:0]}.
- 1 CTRL: bit0 enable, bit1 mute, bit2 clear (self-clearing).
- 2 STATUS, read-only: [15:0] level, bit16 empty, bit17 full, bit18 underrun (sticky), bit19 overflow (sticky).
- 3 VOL: [3:0] right-shift attenuation.
- 4 THRESH: [15:0] low-water mark.
- Reads of addresses 5..7 SHALL return 0.
REQ-012 Writing DATA while the FIFO is full SHALL drop the sample and set overflow; a STATUS read SHALL clear both sticky bits on the following cycle.
REQ-013 Output FSM states: IDLE, LOAD, PRESENT.
- IDLE -> LOAD when enable=1.
- LOAD -> PRESENT after exactly 1 cycle.
- PRESENT -> LOAD once both channels have handshaken.
- Any state -> IDLE when enable=0, but only at a PRESENT completion or when not in PRESENT.
REQ-014 In LOAD, the block SHALL pop the FIFO head into output registers. If the FIFO is empty, it SHALL load 0 into both channels and set underrun.
REQ-015 In PRESENT, each valid SHALL be high until that channel's ready is sampled high, then low. Channels SHALL complete independently, and data SHALL be stable while valid is high.
REQ-016 Output sample SHALL be the signed sample arithmetically right-shifted by VOL. Mute SHALL force 0. The result SHALL be registered at LOAD.
REQ-017 Throughput: one stereo sample per 2 cycles when ready is constantly high; latency from DATA write to valid is 3 cycles when the FIFO is empty and the FSM is in LOAD/IDLE with enable set.
REQ-018 Simultaneous push and pop SHALL leave the level unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 clear SHALL empty the FIFO within 1 cycle.
- A push in the same cycle as clear SHALL be discarded.
- An in-flight PRESENT SHALL complete.

Reset
REQ-020 On reset, the following SHALL be 0:
- FIFO level and pointers
- CTRL, VOL, THRESH
- sticky bits
- left/right_data and left/right_valid
- readdata and irq
REQ-021 On reset, the FSM SHALL enter IDLE. Reset mid-PRESENT SHALL drop valid on the next edge without completing the handshake.

Configuration
REQ-022 With AUDIO_FEEDER_IRQ_EN defined, irq SHALL equal CTRL bit3 (irq enable) AND (level < THRESH OR underrun).
REQ-023 Without AUDIO_FEEDER_IRQ_EN, irq SHALL be tied to 0, CTRL bit3 SHALL read 0, and THRESH SHALL read 0 and ignore writes.

Structure
REQ-024 Package audio_feeder_pkg SHALL hold:
- register address constants
- CTRL/STATUS bit index constants
- the FSM state enum typedef
- the stereo sample struct typedef
REQ-025 The FIFO SHALL be a sub-module sample_fifo:
- single clock, synchronous reset
- push/pop/clear inputs
- full, empty and level outputs
- inferred RAM with a registered head output

Verification
REQ-026 Enable with ready held high; write 0x1234_FF00 -> left_data=0x1234 and right_data=0xFF00 valid 3 cycles later; level returns to 0.
REQ-027 Enable with an empty FIFO -> zero samples are presented and STATUS bit18=1; a STATUS read clears it.
REQ-028 Write FIFO_DEPTH+1 samples with enable=0 -> full=1, overflow=1, level=FIFO_DEPTH, and the last sample is never output.
REQ-029 Hold right_ready low for 10 cycles while left_ready is high -> left_valid drops after 1 cycle, right_data is stable and valid, and the next pop occurs only after right completes.
REQ-030 VOL=4 with sample 0x8000 -> output 0xF800; mute=1 -> output 0x0000.
REQ-031 AUDIO_FEEDER_IRQ_EN defined, THRESH=4, level 5 -> 3 -> irq rises when level<4; assert reset mid-PRESENT -> all outputs 0 next cycle.
